// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: shift modes and FSM states.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to 2**(KW-1) bits, reporting the last bit shifted out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_data,
  output logic             o_bit
);

  logic signed [WIDTH-1:0] w_sdata;
  logic [WIDTH-1:0]        w_up;
  logic [WIDTH-1:0]        w_dn;
  int                      w_kn;

  assign w_sdata = i_data;
  assign w_kn    = int'(i_k);
  // Shifting by k-1 brings the final outgoing bit to an edge where it can be picked off.
  assign w_up    = i_data << (w_kn - 1);
  assign w_dn    = i_data >> (w_kn - 1);

  always_comb begin
    o_data = i_data;
    o_bit  = 1'b0;
    if (i_k != '0) begin
      case (i_mode)
        SH_LSL: begin
          o_data = i_data << w_kn;
          o_bit  = w_up[WIDTH-1];
        end
        SH_LSR: begin
          o_data = i_data >> w_kn;
          o_bit  = w_dn[0];
        end
        SH_ASR: begin
          o_data = $unsigned(w_sdata >>> w_kn);
          o_bit  = w_dn[0];
        end
        SH_ROR: begin
          o_data = (i_data >> w_kn) | (i_data << (WIDTH - w_kn));
          o_bit  = w_dn[0];
        end
        default: begin
          o_data = i_data;
          o_bit  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: shifts STEP bits per cycle behind valid/ready handshakes.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry
);

  localparam int AW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [1:0]       r_mode;
  logic [AW-1:0]    r_rem;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_carry;

  logic [KW-1:0]    w_k;
  logic [AW-1:0]    w_k_aw;
  logic [WIDTH-1:0] w_next;
  logic             w_bit;
  logic             w_accept;

  // k = min(STEP, remaining) keeps the counter from ever underflowing.
  assign w_k      = (r_rem >= AW'(STEP)) ? KW'(STEP) : r_rem[KW-1:0];
  assign w_k_aw   = AW'(w_k);
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .i_data (r_work),
    .i_mode (r_mode),
    .i_k    (w_k),
    .o_data (w_next),
    .o_bit  (w_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (!in_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (in_amt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: w_state_nxt = (r_rem == w_k_aw) ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_state_nxt = out_ready ? ST_IDLE : ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Working registers are separate from the result registers so the visible result
  // holds its last value while the next operation is in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_work      <= '0;
      r_mode      <= SH_LSL;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_work <= in_data;
        r_mode <= in_mode;
        r_rem  <= in_amt;
        if (in_amt == '0) begin
          r_out_data  <= in_data;
          r_out_carry <= 1'b0;
        end
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_next;
        r_rem  <= r_rem - w_k_aw;
        if (r_rem == w_k_aw) begin
          r_out_data  <= w_next;
          r_out_carry <= w_bit;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: a 16-bit/STEP=1 and a 32-bit/STEP=4 instance against a reference model.
module tb_iter_shifter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_carry;
  logic [15:0] a_in_data = '0, a_out_data;
  logic [3:0]  a_in_amt = '0;
  logic [1:0]  a_in_mode = '0;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_carry;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [4:0]  b_in_amt = '0;
  logic [1:0]  b_in_mode = '0;

  iter_shifter #(.WIDTH(16), .STEP(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_amt(a_in_amt), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_carry(a_out_carry)
  );

  iter_shifter #(.WIDTH(32), .STEP(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_amt(b_in_amt), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_carry(b_out_carry)
  );

  int cur_sel = 0;
  logic        obs_valid, obs_ready, obs_carry;
  logic [31:0] obs_data;
  assign obs_valid = (cur_sel != 0) ? b_out_valid : a_out_valid;
  assign obs_ready = (cur_sel != 0) ? b_in_ready  : a_in_ready;
  assign obs_carry = (cur_sel != 0) ? b_out_carry : a_out_carry;
  assign obs_data  = (cur_sel != 0) ? b_out_data  : {16'h0, a_out_data};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the result equations.
  function automatic void ref_model(input int w, input longint unsigned x, input int n,
                                    input int mode, output longint unsigned res, output bit c);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned sign;
    x = x & mask;
    if (n == 0) begin
      res = x; c = 1'b0;
      return;
    end
    case (mode)
      0: begin res = (x << n) & mask; c = bit'((x >> (w - n)) & 1); end
      1: begin res = x >> n; c = bit'((x >> (n - 1)) & 1); end
      2: begin
        sign = (x >> (w - 1)) & 1;
        res = (x >> n) | ((sign != 0) ? (mask & ~(mask >> n)) : 64'd0);
        c = bit'((x >> (n - 1)) & 1);
      end
      default: begin
        res = ((x >> n) | (x << (w - n))) & mask;
        c = bit'((res >> (w - 1)) & 1);
      end
    endcase
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [31:0] x,
                          input int n, input logic [1:0] m);
    if (sel != 0) begin
      b_in_valid = v; b_in_data = x; b_in_amt = n[4:0]; b_in_mode = m;
    end else begin
      a_in_valid = v; a_in_data = x[15:0]; a_in_amt = n[3:0]; a_in_mode = m;
    end
  endtask

  task automatic set_out_ready(input int sel, input logic r);
    if (sel != 0) b_out_ready = r;
    else          a_out_ready = r;
  endtask

  task automatic run_op(input int sel, input logic [31:0] x, input int n,
                        input logic [1:0] m, input int hold, input string tag);
    int w    = (sel != 0) ? 32 : 16;
    int step = (sel != 0) ? 4 : 1;
    int lat;
    int guard = 0;
    longint unsigned exp_res;
    bit exp_c;
    ref_model(w, longint'(x), n, int'(m), exp_res, exp_c);
    cur_sel = sel;
    @(negedge clk);
    while (!obs_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!obs_ready) begin
      check({tag, "_ready_timeout"}, 64'(obs_ready), 64'd1);
      return;
    end
    drive_in(sel, 1'b1, x, n, m);
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; they must be ignored.
    drive_in(sel, 1'b0, $urandom, int'($urandom_range(0, w - 1)), 2'($urandom));
    lat = 1;
    @(negedge clk);
    while (!obs_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!obs_valid) begin
      check({tag, "_valid_timeout"}, 64'(obs_valid), 64'd1);
      return;
    end
    check({tag, "_data"}, 64'(obs_data), exp_res);
    check({tag, "_carry"}, 64'(obs_carry), 64'(exp_c));
    check({tag, "_latency"}, 64'(lat), 64'((n + step - 1) / step + 1));
    for (int i = 0; i < hold; i++) begin
      drive_in(sel, 1'b1, ~x, 1, 2'b00);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(obs_valid), 64'd1);
      check({tag, "_hold_data"}, {31'd0, obs_carry, obs_data}, {31'd0, exp_c, exp_res[31:0]});
      check({tag, "_hold_ready"}, 64'(obs_ready), 64'd0);
    end
    drive_in(sel, 1'b0, ~x, 1, 2'b00);
    set_out_ready(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(sel, 1'b0);
    check({tag, "_drop_valid"}, {62'd0, obs_valid, obs_ready}, {62'd0, 1'b0, 1'b1});
    check({tag, "_keep_data"}, 64'(obs_data), exp_res);
  endtask

  initial begin
    bit seen_valid;
    int rn, rm;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_a_ctl", {61'd0, a_in_ready, a_out_valid, a_out_carry}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("rst_a_data", 64'(a_out_data), 64'd0);
    check("rst_b_ctl", {61'd0, b_in_ready, b_out_valid, b_out_carry}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("rst_b_data", 64'(b_out_data), 64'd0);

    run_op(0, 32'h8001, 1,  2'b00, 0, "lsl_8001_1");
    run_op(0, 32'h8000, 4,  2'b10, 0, "asr_8000_4");
    run_op(0, 32'hFFFF, 15, 2'b01, 0, "lsr_ffff_15");
    run_op(0, 32'h0001, 1,  2'b11, 0, "ror_0001_1");
    for (int md = 0; md < 4; md++) run_op(0, 32'hA5A5, 0, 2'(md), 0, "amt0");
    run_op(0, 32'h1234, 7,  2'b11, 3, "backpressure");
    run_op(1, 32'h1,    6,  2'b00, 0, "w32_lsl_1_6");
    run_op(1, 32'h8000_0001, 31, 2'b10, 2, "w32_asr_31");

    // Reset during an n=10 shift must discard the operation.
    cur_sel = 0;
    @(negedge clk);
    drive_in(0, 1'b1, 32'h0000_F0F0, 10, 2'b00);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 32'h0, 0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_ctl", {61'd0, a_in_ready, a_out_valid, a_out_carry}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("midrst_data", 64'(a_out_data), 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_stale", 64'(seen_valid), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rn = int'($urandom_range(0, 15));
      rm = int'($urandom_range(0, 3));
      run_op(0, $urandom, rn, 2'(rm), int'($urandom_range(0, 2)), "rand_a");
    end
    for (int i = 0; i < 40; i++) begin
      rn = int'($urandom_range(0, 31));
      rm = int'($urandom_range(0, 3));
      run_op(1, $urandom, rn, 2'(rm), int'($urandom_range(0, 2)), "rand_b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
